multdiv_ctrl: RTL and testbench

- Sequencer and datapath for iterative signed 32-bit multiply and divide.
- Drives the team's 5-bit cycle counter through cnt_en/cnt_clr and consumes its count[4:0] to know when the 32nd iteration has run.
- Sits between the processor's execute stage and the counter: takes start pulses and operands, returns result, exception and ready.

---
 rtl/multdiv_ctrl_if.sv | 28 ++
 rtl/multdiv_ctrl.sv | 146 ++++++++++++++
 tb/tb_multdiv_ctrl.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/multdiv_ctrl_if.sv
// Execute-stage / counter side signals of the iterative multiply-divide sequencer.
// master: execute stage plus external counter; slave: multdiv_ctrl.
interface multdiv_ctrl_if #(
    parameter int unsigned WIDTH = 32
);
    localparam int unsigned CNT_W = 5;

    logic             ctrl_mult;
    logic             ctrl_div;
    logic [WIDTH-1:0] data_a;
    logic [WIDTH-1:0] data_b;
    logic [CNT_W-1:0] count;
    logic             cnt_en;
    logic             cnt_clr;
    logic [WIDTH-1:0] result;
    logic             exception;
    logic             ready;

    modport master (
        output ctrl_mult, ctrl_div, data_a, data_b, count,
        input  cnt_en, cnt_clr, result, exception, ready
    );

    modport slave (
        input  ctrl_mult, ctrl_div, data_a, data_b, count,
        output cnt_en, cnt_clr, result, exception, ready
    );
endinterface

// File: rtl/multdiv_ctrl.sv
// Iterative signed 32-bit Booth multiply / restoring divide, paced by an external 5-bit counter.
// Optional MULTDIV_OVF_EN: flag multiply overflow and MIN/-1 divide in exception.
module multdiv_ctrl #(
    parameter int unsigned WIDTH = 32
) (
    input  logic           clk,
    input  logic           clr,
    multdiv_ctrl_if.slave  bus
);
    localparam int unsigned AW    = WIDTH + 1;
    localparam int unsigned CNT_W = 5;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

    state_t           r_state, w_next;
    logic             r_op_div, r_neg, r_qm1;
    logic [WIDTH-1:0] r_a, r_b, r_q, r_m;
    logic [AW-1:0]    r_acc;
    logic [WIDTH-1:0] r_result;
    logic             r_exception, r_ready, r_cnt_en, r_cnt_clr;

    logic             w_start;
    logic [AW-1:0]    w_m_ext, w_sum, w_rem_sh, w_trial, w_acc_nx;
    logic [WIDTH-1:0] w_q_nx, w_quot;
    logic             w_qm1_nx, w_fin_exc;

    assign w_start = bus.ctrl_mult | bus.ctrl_div;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_start) w_next = S_LOAD;
            S_LOAD: w_next = (r_op_div && (r_b == '0)) ? S_DONE : S_RUN;
            S_RUN:  if (bus.count == LAST_CNT) w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // One iteration: 33-bit accumulator absorbs the -MIN case in Booth and the trial subtract.
    always_comb begin
        w_m_ext  = {r_m[WIDTH-1], r_m};
        w_sum    = r_acc;
        w_rem_sh = {r_acc[WIDTH-1:0], r_q[WIDTH-1]};
        w_trial  = w_rem_sh - {1'b0, r_m};
        w_acc_nx = r_acc;
        w_q_nx   = r_q;
        w_qm1_nx = r_qm1;
        if (r_op_div) begin
            if (w_trial[WIDTH]) begin
                w_acc_nx = w_rem_sh;
                w_q_nx   = {r_q[WIDTH-2:0], 1'b0};
            end else begin
                w_acc_nx = w_trial;
                w_q_nx   = {r_q[WIDTH-2:0], 1'b1};
            end
        end else begin
            case ({r_q[0], r_qm1})
                2'b01:   w_sum = r_acc + w_m_ext;
                2'b10:   w_sum = r_acc - w_m_ext;
                default: w_sum = r_acc;
            endcase
            w_acc_nx = {w_sum[AW-1], w_sum[AW-1:1]};
            w_q_nx   = {w_sum[0], r_q[WIDTH-1:1]};
            w_qm1_nx = r_q[0];
        end
    end

    assign w_quot = r_neg ? -w_q_nx : w_q_nx;

`ifdef MULTDIV_OVF_EN
    logic w_mul_ovf, w_div_ovf;
    assign w_mul_ovf = (w_acc_nx[WIDTH-1:0] != {WIDTH{w_q_nx[WIDTH-1]}});
    assign w_div_ovf = (r_a == {1'b1, {(WIDTH-1){1'b0}}}) && (r_b == '1);
    assign w_fin_exc = r_op_div ? w_div_ovf : w_mul_ovf;
`else
    assign w_fin_exc = 1'b0;
`endif

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_op_div    <= 1'b0;
            r_neg       <= 1'b0;
            r_qm1       <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_q         <= '0;
            r_m         <= '0;
            r_acc       <= '0;
            r_result    <= '0;
            r_exception <= 1'b0;
            r_ready     <= 1'b0;
            r_cnt_en    <= 1'b0;
            r_cnt_clr   <= 1'b0;
        end else begin
            r_ready   <= (w_next == S_DONE);
            r_cnt_en  <= (w_next == S_RUN);
            r_cnt_clr <= (w_next == S_LOAD);
            case (r_state)
                S_IDLE: if (w_start) begin
                    r_op_div <= ~bus.ctrl_mult;
                    r_a      <= bus.data_a;
                    r_b      <= bus.data_b;
                end
                S_LOAD: begin
                    r_acc <= '0;
                    r_qm1 <= 1'b0;
                    if (r_op_div) begin
                        r_q   <= r_a[WIDTH-1] ? -r_a : r_a;
                        r_m   <= r_b[WIDTH-1] ? -r_b : r_b;
                        r_neg <= r_a[WIDTH-1] ^ r_b[WIDTH-1];
                        if (r_b == '0) begin
                            r_result    <= '0;
                            r_exception <= 1'b1;
                        end
                    end else begin
                        r_q <= r_b;
                        r_m <= r_a;
                    end
                end
                S_RUN: begin
                    r_acc <= w_acc_nx;
                    r_q   <= w_q_nx;
                    r_qm1 <= w_qm1_nx;
                    if (w_next == S_DONE) begin
                        r_result    <= r_op_div ? w_quot : w_q_nx;
                        r_exception <= w_fin_exc;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.result    = r_result;
    assign bus.exception = r_exception;
    assign bus.ready     = r_ready;
    assign bus.cnt_en    = r_cnt_en;
    assign bus.cnt_clr   = r_cnt_clr;
endmodule

// File: tb/tb_multdiv_ctrl.sv
// Scoreboard bench for multdiv_ctrl: driver pushes expected results, monitor checks on ready.
module tb_multdiv_ctrl;
`ifdef MULTDIV_OVF_EN
    localparam logic OVF = 1'b1;
`else
    localparam logic OVF = 1'b0;
`endif

    typedef struct {
        logic [31:0] res;
        logic        exc;
        int          lat;
        int          en;
        int          start;
        string       name;
    } exp_t;

    logic clk, clr;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    exp_t sb[$];

    multdiv_ctrl_if bus ();

    multdiv_ctrl dut (.clk(clk), .clr(clr), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Model of the external 5-bit cycle counter
    always @(posedge clk or negedge clr) begin
        if (!clr)             bus.count <= '0;
        else if (bus.cnt_clr) bus.count <= '0;
        else if (bus.cnt_en)  bus.count <= bus.count + 5'd1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic start_op(input logic do_mult, input logic do_div,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] er, input logic ee,
                            input int lat, input int en, input string nm);
        exp_t e;
        @(negedge clk);
        bus.ctrl_mult = do_mult;
        bus.ctrl_div  = do_div;
        bus.data_a    = a;
        bus.data_b    = b;
        e.res = er; e.exc = ee; e.lat = lat; e.en = en; e.start = cyc + 1; e.name = nm;
        sb.push_back(e);
        @(negedge clk);
        bus.ctrl_mult = 1'b0;
        bus.ctrl_div  = 1'b0;
        bus.data_a    = $urandom;
        bus.data_b    = $urandom;
    endtask

    task automatic wait_done(input string nm);
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s_timeout: %0d results still pending, required 0", nm, sb.size());
            sb.delete();
        end
    endtask

    task automatic run_op(input logic do_mult, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] er, input logic ee, input string nm);
        start_op(do_mult, ~do_mult, a, b, er, ee, 33, 32, nm);
        wait_done(nm);
    endtask

    task automatic wait_run_count(input logic [4:0] c, output logic found);
        found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (bus.cnt_en && bus.count == c) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Monitor: tallies counter strobes per op and checks each completion against the scoreboard
    initial begin
        int   en_n, clr_n, ovl;
        exp_t e;
        en_n = 0; clr_n = 0; ovl = 0;
        forever begin
            @(negedge clk);
            if (!clr) begin
                en_n = 0; clr_n = 0; ovl = 0;
            end else begin
                if (bus.cnt_en)                en_n++;
                if (bus.cnt_clr)               clr_n++;
                if (bus.cnt_en && bus.cnt_clr) ovl++;
                if (bus.ready) begin
                    if (sb.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL spurious_ready: ready with nothing outstanding, result %h", bus.result);
                    end else begin
                        e = sb.pop_front();
                        chk({e.name, "_result"},    bus.result,             e.res);
                        chk({e.name, "_exception"}, 32'(bus.exception),     32'(e.exc));
                        chk({e.name, "_latency"},   32'(cyc - e.start),     32'(e.lat));
                        chk({e.name, "_cnt_en"},    32'(en_n),              32'(e.en));
                        chk({e.name, "_cnt_clr"},   32'(clr_n),             32'd1);
                        chk({e.name, "_en_clr_overlap"}, 32'(ovl),          32'd0);
                    end
                    en_n = 0; clr_n = 0; ovl = 0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic found;
        clr = 1'b0;
        bus.ctrl_mult = 1'b0;
        bus.ctrl_div  = 1'b0;
        bus.data_a    = '0;
        bus.data_b    = '0;
        repeat (3) @(negedge clk);
        chk("reset_result",    bus.result,           32'h0);
        chk("reset_exception", 32'(bus.exception),   32'h0);
        chk("reset_ready",     32'(bus.ready),       32'h0);
        chk("reset_cnt_en",    32'(bus.cnt_en),      32'h0);
        chk("reset_cnt_clr",   32'(bus.cnt_clr),     32'h0);
        clr = 1'b1;

        run_op(1'b1, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, "mul_7_x_m3");
        run_op(1'b0, 32'hFFFF_FF9C, 32'd7,        32'hFFFF_FFF2, 1'b0, "div_m100_7");
        run_op(1'b0, 32'd100,      32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0, "div_100_m7");
        run_op(1'b0, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'h0000_000E, 1'b0, "div_m100_m7");

        start_op(1'b0, 1'b1, 32'd5, 32'd0, 32'h0, 1'b1, 1, 0, "div_5_0");
        wait_done("div_5_0");

        run_op(1'b1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, OVF,  "mul_ovf");
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, OVF,  "mul_min_x_m1");
        run_op(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, "mul_m1_x_m1");
        run_op(1'b0, 32'd7,        32'hFFFF_FF9C, 32'h0000_0000, 1'b0, "div_7_m100");
        run_op(1'b0, 32'h7FFF_FFFF, 32'd1,        32'h7FFF_FFFF, 1'b0, "div_max_1");

        // Divide start mid-multiply must be dropped
        start_op(1'b1, 1'b0, 32'hFFFF_FFFA, 32'd5, 32'hFFFF_FFE2, 1'b0, 33, 32, "mul_ignore_div");
        wait_run_count(5'd10, found);
        chk("ignore_reach_run10", 32'(found), 32'h1);
        bus.ctrl_div = 1'b1;
        bus.data_a   = 32'd11;
        bus.data_b   = 32'd0;
        @(negedge clk);
        bus.ctrl_div = 1'b0;
        wait_done("mul_ignore_div");
        repeat (5) @(negedge clk);

        start_op(1'b1, 1'b1, 32'd9, 32'hFFFF_FFFE, 32'hFFFF_FFEE, 1'b0, 33, 32, "both_start_mul");
        wait_done("both_start_mul");

        run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, OVF, "div_min_m1");

        // Asynchronous reset in the middle of a run
        start_op(1'b1, 1'b0, 32'h0000_1234, 32'h0000_0011, 32'h0, 1'b0, 33, 32, "mul_aborted");
        wait_run_count(5'd15, found);
        chk("abort_reach_run15", 32'(found), 32'h1);
        #2 clr = 1'b0;
        #1;
        chk("abort_result",    bus.result,         32'h0);
        chk("abort_exception", 32'(bus.exception), 32'h0);
        chk("abort_ready",     32'(bus.ready),     32'h0);
        chk("abort_cnt_en",    32'(bus.cnt_en),    32'h0);
        chk("abort_cnt_clr",   32'(bus.cnt_clr),   32'h0);
        sb.delete();
        @(negedge clk);
        clr = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_idle_cnt_clr", 32'(bus.cnt_clr), 32'h0);
        chk("abort_idle_ready",   32'(bus.ready),   32'h0);

        run_op(1'b1, 32'd3, 32'd4, 32'h0000_000C, 1'b0, "mul_3_x_4");

        repeat (10) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
